packet_rr_drain_arbiter: RTL and testbench

Round-robin arbiter that drains NUM_SRC upstream packet FIFOs onto one egress packet link. Each FIFO exposes empty/rd_en/rd_data, and each FIFO registers its rd_data one cycle after an accepted rd_en. The arbiter pops one packet per grant and registers it onto a valid/ready output stream tagged with its source index. It sits between the per-port ingress FIFOs and the shared chiplet egress serializer, and keeps a per-source packet counter for debug.

---
 rtl/pkt_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/packet_rr_drain_arbiter.sv | 112 +++++++++++
 tb/tb_packet_rr_drain_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet drain arbiter and its helpers.
package pkt_pkg;

  // Default width of one packet in bits.
  localparam int PKT_WIDTH_DEF = 128;

  // Arbiter FSM: pick a source, pop its FIFO, capture the read data, offer it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It searches upward from the index just
// after last_grant and wraps around, returning the first requester it finds.
module rr_pick #(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic               any,
  output logic [SRC_W-1:0]   grant
);

  logic [SRC_W-1:0] idx;

  // Scan the NUM_SRC candidates in priority order; the first hit wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/packet_rr_drain_arbiter.sv
// Drains NUM_SRC upstream packet FIFOs onto one egress stream, one packet per
// grant, in strict round-robin order. Keeps a per-source forwarded counter.
//
// Egress handshake: out_valid/out_data/out_src are registered; once out_valid
// rises they stay unchanged until a cycle with out_valid & out_ready, which is
// the single transfer point. out_ready may toggle freely and is never used to
// produce out_valid.
module packet_rr_drain_arbiter
  import pkt_pkg::*;
#(
  parameter  int PACKET_WIDTH = PKT_WIDTH_DEF,
  parameter  int NUM_SRC      = 4,
  parameter  int CNT_W        = 16,
  localparam int SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        cfg_src_en,
  input  logic [NUM_SRC-1:0]        fifo_empty,
  output logic [NUM_SRC-1:0]        fifo_rd_en,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0] fifo_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PACKET_WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      busy,
  output logic [NUM_SRC*CNT_W-1:0]  src_pkt_cnt,
  output arb_state_e                dbg_state
);

  arb_state_e           state, state_nxt;
  logic [SRC_W-1:0]     grant, last_grant;
  logic [NUM_SRC-1:0]   req;
  logic                 pick_any;
  logic [SRC_W-1:0]     pick_grant;
  logic                 out_hs;
  logic [CNT_W-1:0]     cnt [NUM_SRC];

  // A disabled source is invisible to the picker.
  assign req    = cfg_src_en & ~fifo_empty;
  assign out_hs = out_valid & out_ready;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .any        (pick_any),
    .grant      (pick_grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the pop strobe, which is only ever raised in POP.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = '0;
    case (state)
      IDLE: if (pick_any) state_nxt = POP;
      POP: begin
        fifo_rd_en[grant] = 1'b1;
        state_nxt         = CAPT;
      end
      CAPT: state_nxt = SEND;
      SEND: if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, round-robin pointer and the registered egress stage.
  // last_grant resets to the top index so source 0 is looked at first.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) grant <= pick_grant;
        CAPT: begin
          out_data   <= fifo_rd_data[int'(grant)*PACKET_WIDTH +: PACKET_WIDTH];
          out_src    <= grant;
          out_valid  <= 1'b1;
          last_grant <= grant;
        end
        SEND: if (out_hs) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Per-source forwarded-packet counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else if (state == SEND && out_hs) begin
      cnt[out_src] <= cnt[out_src] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_flat
    assign src_pkt_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_packet_rr_drain_arbiter.sv
// Bench for packet_rr_drain_arbiter: behavioural upstream FIFOs, a table of
// drain scenarios, hand-written multi-cycle sequences and an egress scoreboard.
module tb_packet_rr_drain_arbiter;
  import pkt_pkg::*;

  localparam int PW = 128;
  localparam int NS = 4;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     cfg_src_en = '1;
  logic [NS-1:0]     fifo_empty;
  logic [NS-1:0]     fifo_rd_en;
  logic [NS*PW-1:0]  fifo_rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              busy;
  logic [NS*CW-1:0]  src_pkt_cnt;
  arb_state_e        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_hs_cyc = 0;

  logic [SW+PW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  packet_rr_drain_arbiter #(.PACKET_WIDTH(PW), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_src_en   (cfg_src_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src      (out_src),
    .busy         (busy),
    .src_pkt_cnt  (src_pkt_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- upstream FIFO models ----------------
  logic [PW-1:0] mem [NS][DEPTH];
  logic [PW-1:0] rd_data_r [NS];
  int wp [NS];
  int rp [NS];

  for (genvar g = 0; g < NS; g++) begin : g_fifo
    assign fifo_empty[g] = (wp[g] == rp[g]);
    assign fifo_rd_data[g*PW +: PW] = rd_data_r[g];
  end

  // Read data appears one cycle after an accepted pop.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (fifo_rd_en[i] && wp[i] != rp[i]) begin
        rd_data_r[i] <= mem[i][rp[i] % DEPTH];
        rp[i]        <= rp[i] + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [CW-1:0] get_cnt(input int s);
    return src_pkt_cnt[s*CW +: CW];
  endfunction

  task automatic push_pkt(input int s, input logic [PW-1:0] d);
    mem[s][wp[s] % DEPTH] = d;
    wp[s] = wp[s] + 1;
  endtask

  task automatic expect_pkt(input int s, input logic [PW-1:0] d);
    exp_q.push_back({SW'(s), d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    cfg_src_en = '1;
    for (int i = 0; i < NS; i++) wp[i] = rp[i];
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data_src", {out_src, out_data}, 0);
    check("rst_counters", src_pkt_cnt, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_in_budget", n < budget, 1);
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    logic [SW+PW-1:0] e;
    if (!rst) begin
      check("rd_en_onehot0", $countones(fifo_rd_en) <= 1, 1);
      for (int i = 0; i < NS; i++)
        if (fifo_rd_en[i]) check("rd_en_on_empty", fifo_empty[i], 0);
      if (out_valid && out_ready) begin
        check("pkt_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pkt_src_data", {out_src, out_data}, e);
        end
        last_hs_cyc = cyc;
      end
    end
  end

  // ---------------- vector table ----------------
  // npk[s] = packets loaded into FIFO s; seq = expected egress source order.
  typedef struct {
    string       name;
    logic [3:0]  en;
    string       npk;
    string       seq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [PW-1:0] dat [NS][8];
    int used [NS];
    int start_cyc;
    int s;
    logic [PW-1:0] d1, d2;

    tbl[0] = '{"single_src2",    4'b1111, "0010", "2"};
    tbl[1] = '{"round_robin",    4'b1111, "2222", "01230123"};
    tbl[2] = '{"mask_1010",      4'b1010, "2222", "1313"};
    tbl[3] = '{"mixed_0_2",      4'b1111, "3010", "0200"};
    tbl[4] = '{"mask_0110",      4'b0110, "1111", "12"};
    tbl[5] = '{"mask_1001_wrap", 4'b1001, "1002", "033"};

    for (int t = 0; t < 6; t++) begin
      reset_dut();
      step();
      cfg_src_en = tbl[t].en;
      out_ready  = 1'b1;
      for (int i = 0; i < NS; i++) begin
        used[i] = 0;
        for (int k = 0; k < int'(tbl[t].npk[i] - 8'h30); k++) begin
          dat[i][k] = rnd128();
          push_pkt(i, dat[i][k]);
        end
      end
      for (int k = 0; k < tbl[t].seq.len(); k++) begin
        s = int'(tbl[t].seq[k] - 8'h30);
        expect_pkt(s, dat[s][used[s]]);
        used[s]++;
      end
      start_cyc = cyc;
      wait_drain(4 * tbl[t].seq.len() + 20);
      check({tbl[t].name, "_last_hs_cycle"}, last_hs_cyc - start_cyc,
            4 * tbl[t].seq.len() - 1);
      for (int i = 0; i < NS; i++) begin
        check({tbl[t].name, "_count"}, get_cnt(i), CW'(used[i]));
        check({tbl[t].name, "_left"}, wp[i] - rp[i],
              int'(tbl[t].npk[i] - 8'h30) - used[i]);
      end
    end

    // Single source, cycle by cycle: pop pulse, 3-cycle latency.
    reset_dut();
    step();
    out_ready = 1'b1;
    d1 = {16{8'hA5}};
    push_pkt(2, d1);
    expect_pkt(2, d1);
    @(negedge clk);
    check("ss_rd_en_c0", fifo_rd_en, 4'b0000);
    @(negedge clk);
    check("ss_rd_en_c1", fifo_rd_en, 4'b0100);
    check("ss_state_c1", dbg_state, POP);
    @(negedge clk);
    check("ss_rd_en_c2", fifo_rd_en, 4'b0000);
    check("ss_valid_c2", out_valid, 0);
    @(negedge clk);
    check("ss_valid_c3", out_valid, 1);
    check("ss_data_c3", {out_src, out_data}, {2'd2, d1});
    @(negedge clk);
    check("ss_valid_c4", out_valid, 0);
    check("ss_cnt2", get_cnt(2), 1);

    // Backpressure: stall 10 cycles, a second source waits behind it.
    reset_dut();
    step();
    d1 = rnd128();
    d2 = rnd128();
    push_pkt(1, d1);
    push_pkt(2, d2);
    expect_pkt(1, d1);
    expect_pkt(2, d2);
    wait_valid(10);
    repeat (10) begin
      check("bp_valid", out_valid, 1);
      check("bp_data_src", {out_src, out_data}, {2'd1, d1});
      check("bp_no_pop", fifo_rd_en, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after_hs", dbg_state, IDLE);
    check("bp_cnt1", get_cnt(1), 1);
    wait_drain(20);
    check("bp_cnt2", get_cnt(2), 1);

    // Reset while a packet is being offered.
    reset_dut();
    step();
    out_ready = 1'b1;
    d1 = rnd128();
    push_pkt(1, d1);
    expect_pkt(1, d1);
    wait_drain(20);
    step();
    out_ready = 1'b0;
    push_pkt(3, rnd128());
    wait_valid(10);
    check("rs_src_before", out_src, 3);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    d1 = rnd128();
    d2 = rnd128();
    push_pkt(2, d2);
    push_pkt(0, d1);
    expect_pkt(0, d1);
    expect_pkt(2, d2);
    @(negedge clk);
    check("rs_valid_cleared", out_valid, 0);
    check("rs_counters_cleared", src_pkt_cnt, 0);
    wait_drain(20);
    check("rs_cnt0", get_cnt(0), 1);
    check("rs_cnt1", get_cnt(1), 0);
    check("rs_cnt3", get_cnt(3), 0);

    // Counter wrap: 17 packets through a 4-bit counter.
    reset_dut();
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      d1 = rnd128();
      push_pkt(0, d1);
      expect_pkt(0, d1);
    end
    wait_drain(17 * 4 + 20);
    check("wrap_cnt0", get_cnt(0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
